sort_block_loader: RTL and testbench

- Upstream feeder for the bitonic sorting network `BN`.
- Accepts a serial stream of `DW`-bit words on a valid/ready handshake and packs them into a `2**LP`-lane vector.
- Pads short blocks with all-ones so that, after ascending sort, the padding lands in the top lanes.
- Presents each completed block on a registered valid/ready output whose `out_data` drives the `BN` input vector directly.

---
 rtl/sort_pkg.sv | 16 +
 rtl/sort_block_loader.sv | 108 ++++++++++
 tb/tb_sort_block_loader.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the bitonic sort datapath: default geometry,
// padding value and the block loader state encoding.
package sort_pkg;

  localparam int SORT_DW = 16;
  localparam int SORT_LP = 4;

  // All-ones padding sorts to the top lanes in an ascending network.
  localparam logic [SORT_DW-1:0] SORT_PAD = '1;

  typedef enum logic {
    LD_FILL = 1'b0,
    LD_HOLD = 1'b1
  } ld_state_e;

endpackage

// File: rtl/sort_block_loader.sv
// Packs a serial word stream into 2**LP-lane blocks for the bitonic network,
// padding short blocks with all-ones and holding one block of backpressure.
import sort_pkg::*;

module sort_block_loader #(
  parameter int DW = SORT_DW,
  parameter int LP = SORT_LP
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DW-1:0]               in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2**LP-1:0][DW-1:0]    out_data,
  output logic [LP:0]                 out_count,
  output ld_state_e                   dbg_state
);

  localparam int N = 2**LP;

  // Handshakes: a word moves when in_valid && in_ready; a block moves when
  // out_valid && out_ready. in_ready depends only on state and rst.

  logic [DW-1:0]          fill_buf [N];
  logic [LP-1:0]          idx;
  ld_state_e              state;
  logic                   accept;
  logic                   close;
  logic                   slot_free;
  logic [LP:0]            blk_count;
  logic [N-1:0][DW-1:0]   load_vec;

  assign in_ready  = !rst && (state == LD_FILL);
  assign accept    = in_valid && in_ready;
  assign close     = accept && (in_last || (idx == LP'(N - 1)));
  assign slot_free = !out_valid || out_ready;
  assign blk_count = {1'b0, idx} + (LP+1)'(1);
  assign dbg_state = state;

  // In FILL the closing word bypasses the buffer; in HOLD it is already there.
  always_comb begin
    load_vec = '0;
    for (int i = 0; i < N; i++) begin
      if ((LP+1)'(i) < blk_count) begin
        if (state == LD_FILL && LP'(i) == idx) begin
          load_vec[i] = in_data;
        end else begin
          load_vec[i] = fill_buf[i];
        end
      end else begin
        load_vec[i] = {DW{1'b1}};
      end
    end
  end

  // Fill buffer is never cleared; stale lanes are masked on load.
  always_ff @(posedge clk) begin
    if (accept) begin
      fill_buf[idx] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LD_FILL;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      unique case (state)
        LD_FILL: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
          if (accept) begin
            if (close) begin
              if (slot_free) begin
                out_data  <= load_vec;
                out_count <= blk_count;
                out_valid <= 1'b1;
                idx       <= '0;
              end else begin
                state <= LD_HOLD;
              end
            end else begin
              idx <= idx + LP'(1);
            end
          end
        end
        LD_HOLD: begin
          if (out_ready) begin
            out_data  <= load_vec;
            out_count <= blk_count;
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= LD_FILL;
          end
        end
        default: state <= LD_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_block_loader.sv
// Bench for sort_block_loader at N=4, DW=16: scoreboard of expected blocks
// checked on every output transfer, plus directed handshake checks.
import sort_pkg::*;

module tb_sort_block_loader;

  localparam int DW = 16;
  localparam int LP = 2;
  localparam int N  = 4;
  localparam int VW = LP + 1 + N*DW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        in_data;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [N-1:0][DW-1:0] out_data;
  logic [LP:0]          out_count;
  ld_state_e            dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_xfer   = 0;
  logic [VW-1:0] exp_q[$];

  sort_block_loader #(.DW(DW), .LP(LP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference model of the downstream ascending sorter.
  function automatic logic [N*DW-1:0] sort_vec(input logic [N*DW-1:0] v);
    logic [DW-1:0] l [N];
    logic [DW-1:0] t;
    for (int i = 0; i < N; i++) l[i] = v[i*DW +: DW];
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N-1-i; j++)
        if (l[j] > l[j+1]) begin t = l[j]; l[j] = l[j+1]; l[j+1] = t; end
    for (int i = 0; i < N; i++) sort_vec[i*DW +: DW] = l[i];
  endfunction

  function automatic logic [VW-1:0] make_exp(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                             input logic [DW-1:0] w2, input logic [DW-1:0] w3,
                                             input int cnt);
    logic [DW-1:0] w [N];
    logic [N*DW-1:0] d;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = (i < cnt) ? w[i] : 16'hFFFF;
    make_exp = {(LP+1)'(cnt), d};
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [VW-1:0] e;
      n_xfer++;
      if (exp_q.size() == 0) begin
        check("unexpected_block", 0, 1);
      end else begin
        e = exp_q.pop_front();
        check("out_count", out_count, e[VW-1 -: LP+1]);
        check("out_data", out_data, e[N*DW-1:0]);
        check("sorted", sort_vec(out_data), sort_vec(e[N*DW-1:0]));
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic last);
    int w = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [VW-1:0] blk_a, blk_b, e;
    int low, ov, x0;
    logic [DW-1:0] r [12];

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_count", out_count, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    // Full block, latency of one cycle after the closing accept
    out_ready = 1'b1;
    exp_q.push_back(make_exp(7, 3, 9, 1, 4));
    send(7, 0); send(3, 0); send(9, 0); send(1, 0);
    check("t1_latency", out_valid, 1);
    repeat (3) @(posedge clk); #1;

    // Short block closed by in_last
    exp_q.push_back(make_exp(5, 2, 0, 0, 2));
    send(5, 0); send(2, 1);
    check("t2_latency", out_valid, 1);
    repeat (3) @(posedge clk); #1;

    // Single-word block
    exp_q.push_back(make_exp(16'h00AA, 0, 0, 0, 1));
    send(16'h00AA, 1);
    repeat (3) @(posedge clk); #1;

    // Backpressure: A held, B parks in HOLD, then both move
    out_ready = 1'b0;
    blk_a = make_exp(1, 2, 3, 4, 4);
    blk_b = make_exp(8, 7, 6, 5, 4);
    exp_q.push_back(blk_a);
    exp_q.push_back(blk_b);
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    send(8, 0); send(7, 0); send(6, 0); send(5, 0);
    check("t3_in_ready_low", in_ready, 0);
    check("t3_state_hold", dbg_state, LD_HOLD);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("t3_a_stable", out_data, blk_a[N*DW-1:0]);
      check("t3_a_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t3_b_valid", out_valid, 1);
    check("t3_b_loaded", out_data, blk_b[N*DW-1:0]);
    check("t3_in_ready_back", in_ready, 1);
    repeat (3) @(posedge clk); #1;

    // Back-to-back streaming of three blocks
    for (int i = 0; i < 12; i++) r[i] = DW'($urandom_range(0, 16'hFFFE));
    for (int b = 0; b < 3; b++) begin
      e = make_exp(r[4*b], r[4*b+1], r[4*b+2], r[4*b+3], 4);
      exp_q.push_back(e);
    end
    x0 = n_xfer; low = 0; ov = 0;
    fork
      for (int i = 0; i < 12; i++) send(r[i], 0);
      begin
        repeat (16) begin
          @(negedge clk);
          if (!in_ready) low++;
          if (out_valid) ov++;
        end
      end
    join
    check("t4_no_stall", low, 0);
    check("t4_valid_cycles", ov, 3);
    check("t4_blocks", n_xfer - x0, 3);
    repeat (2) @(posedge clk); #1;

    // Mid-block reset leaves no residue
    send(16'h1111, 0); send(16'h2222, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_out_count", out_count, 0);
    exp_q.push_back(make_exp(4, 3, 2, 1, 4));
    send(4, 0); send(3, 0); send(2, 0); send(1, 0);
    repeat (4) @(posedge clk); #1;

    check("q_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
